// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS execute-stage controller.
package mips_pkg;

   typedef logic [31:0] size_t;

   typedef logic [1:0] state_t;
   localparam state_t ST_FETCH = 2'd0;
   localparam state_t ST_EXEC  = 2'd1;
   localparam state_t ST_HALT  = 2'd2;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
      OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
      OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
      OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f,
      OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
      OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2b
   } opcode_t;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
      FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
      FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13,
      FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
      FN_SUB  = 6'h22, FN_SUBU  = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
      FN_XOR  = 6'h26, FN_NOR   = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b
   } func_t;

   typedef enum logic [4:0] {
      RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11
   } regimm_t;

   typedef enum logic [1:0] {
      DEST_RD = 2'd0, DEST_RT = 2'd1, DEST_R31 = 2'd2
   } dest_sel_t;

   function automatic size_t sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mips_exec_alu.sv
// Combinational execute datapath: results, branch/jump/memory address,
// branch condition and byte-lane alignment for loads and stores.
module mips_exec_alu
   import mips_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] ram_readdata_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [31:0] wb_data_o,
   output logic [31:0] store_data_o,
   output logic [31:0] effective_address_o,
   output logic [3:0]  mem_byte_en_o,
   output logic        b_cond_met_o
);

   logic [5:0] op, fn;
   logic [4:0] sa, rt_f;
   size_t      simm, zimm, pc4, pc8, br_target, mem_addr, mem_aligned;
   logic [1:0] off;
   logic [7:0] ld_byte;
   logic [15:0] ld_half;

   assign op          = instr_i[31:26];
   assign fn          = instr_i[5:0];
   assign sa          = instr_i[10:6];
   assign rt_f        = instr_i[20:16];
   assign simm        = sext16(instr_i[15:0]);
   assign zimm        = {16'h0, instr_i[15:0]};
   assign pc4         = pc_i + 32'd4;
   assign pc8         = pc_i + 32'd8;
   assign br_target   = pc4 + {simm[29:0], 2'b00};
   assign mem_addr    = rs_i + simm;
   assign mem_aligned = {mem_addr[31:2], 2'b00};
   assign off         = mem_addr[1:0];

   // Read data is big-endian: byte offset 0 sits in the top lane.
   always_comb begin
      case (off)
         2'd0:    ld_byte = ram_readdata_i[31:24];
         2'd1:    ld_byte = ram_readdata_i[23:16];
         2'd2:    ld_byte = ram_readdata_i[15:8];
         default: ld_byte = ram_readdata_i[7:0];
      endcase
   end
   assign ld_half = off[1] ? ram_readdata_i[15:0] : ram_readdata_i[31:16];

   always_comb begin
      wb_data_o           = '0;
      effective_address_o = '0;
      b_cond_met_o        = 1'b0;
      mem_byte_en_o       = 4'h0;
      store_data_o        = rt_i;
      case (op)
         OP_SPECIAL: begin
            case (fn)
               FN_SLL:  wb_data_o = rt_i << sa;
               FN_SRL:  wb_data_o = rt_i >> sa;
               FN_SRA:  wb_data_o = $signed(rt_i) >>> sa;
               FN_SLLV: wb_data_o = rt_i << rs_i[4:0];
               FN_SRLV: wb_data_o = rt_i >> rs_i[4:0];
               FN_SRAV: wb_data_o = $signed(rt_i) >>> rs_i[4:0];
               FN_JR: begin
                  effective_address_o = rs_i;
                  b_cond_met_o        = 1'b1;
               end
               FN_JALR: begin
                  effective_address_o = rs_i;
                  b_cond_met_o        = 1'b1;
                  wb_data_o           = pc8;
               end
               FN_MFHI:         wb_data_o = hi_i;
               FN_MFLO:         wb_data_o = lo_i;
               FN_ADD, FN_ADDU: wb_data_o = rs_i + rt_i;
               FN_SUB, FN_SUBU: wb_data_o = rs_i - rt_i;
               FN_AND:          wb_data_o = rs_i & rt_i;
               FN_OR:           wb_data_o = rs_i | rt_i;
               FN_XOR:          wb_data_o = rs_i ^ rt_i;
               FN_NOR:          wb_data_o = ~(rs_i | rt_i);
               FN_SLT:          wb_data_o = {31'b0, $signed(rs_i) < $signed(rt_i)};
               FN_SLTU:         wb_data_o = {31'b0, rs_i < rt_i};
               default: ;
            endcase
         end
         OP_REGIMM: begin
            case (rt_f)
               RI_BLTZ, RI_BGEZ, RI_BLTZAL, RI_BGEZAL: begin
                  // rt[0] selects GEZ; taken when sign disagrees with that sense.
                  effective_address_o = br_target;
                  b_cond_met_o        = rt_f[0] ^ rs_i[31];
                  wb_data_o           = pc8;
               end
               default: ;
            endcase
         end
         OP_J, OP_JAL: begin
            effective_address_o = {pc4[31:28], instr_i[25:0], 2'b00};
            b_cond_met_o        = 1'b1;
            wb_data_o           = pc8;
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            effective_address_o = br_target;
            case (op)
               OP_BEQ:  b_cond_met_o = (rs_i == rt_i);
               OP_BNE:  b_cond_met_o = (rs_i != rt_i);
               OP_BLEZ: b_cond_met_o = rs_i[31] || (rs_i == '0);
               default: b_cond_met_o = !rs_i[31] && (rs_i != '0);
            endcase
         end
         OP_ADDI, OP_ADDIU: wb_data_o = rs_i + simm;
         OP_SLTI:           wb_data_o = {31'b0, $signed(rs_i) < $signed(simm)};
         OP_SLTIU:          wb_data_o = {31'b0, rs_i < simm};
         OP_ANDI:           wb_data_o = rs_i & zimm;
         OP_ORI:            wb_data_o = rs_i | zimm;
         OP_XORI:           wb_data_o = rs_i ^ zimm;
         OP_LUI:            wb_data_o = {instr_i[15:0], 16'h0};
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            effective_address_o = mem_aligned;
            mem_byte_en_o       = 4'hF;
            case (op)
               OP_LB:   wb_data_o = {{24{ld_byte[7]}}, ld_byte};
               OP_LBU:  wb_data_o = {24'h0, ld_byte};
               OP_LH:   wb_data_o = {{16{ld_half[15]}}, ld_half};
               OP_LHU:  wb_data_o = {16'h0, ld_half};
               default: wb_data_o = ram_readdata_i;
            endcase
         end
         OP_SB: begin
            effective_address_o = mem_aligned;
            mem_byte_en_o       = 4'b0001 << off;
            store_data_o        = {4{rt_i[7:0]}};
         end
         OP_SH: begin
            effective_address_o = mem_aligned;
            mem_byte_en_o       = off[1] ? 4'b1100 : 4'b0011;
            store_data_o        = {2{rt_i[15:0]}};
         end
         OP_SW: begin
            effective_address_o = mem_aligned;
            mem_byte_en_o       = 4'hF;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_exec_ctrl.sv
// MIPS fetch/execute controller: FSM, decode and write strobes.
// Define MIPS_MULT_EN to build HI/LO with MULT/MULTU/MTHI/MTLO/MFHI/MFLO.
module mips_exec_ctrl
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        halt_i,
   input  logic        stall_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] ram_readdata_i,
   output logic [1:0]  state_o,
   output logic        pc_write_en_o,
   output logic        ir_write_en_o,
   output logic        ram_read_en_o,
   output logic        ram_write_en_o,
   output logic [3:0]  ram_byte_en_o,
   output logic        ram_addr_sel_o,
   output logic        regfile_write_en_o,
   output logic [1:0]  regfile_addr_3_sel_o,
   output logic [31:0] wb_data_o,
   output logic [31:0] store_data_o,
   output logic [31:0] effective_address_o,
   output logic        b_cond_met_o
);

   state_t     state;
   logic [5:0] op, fn;
   logic [4:0] rt_f;
   logic       writes_gpr, is_load, is_store;
   dest_sel_t  dest;
   logic [3:0] mem_byte_en;
   size_t      hi, lo;

   assign op   = instr_i[31:26];
   assign fn   = instr_i[5:0];
   assign rt_f = instr_i[20:16];

   always_ff @(posedge clk) begin
      if (reset)          state <= ST_FETCH;
      else if (halt_i)    state <= ST_HALT;
      else if (!stall_i) begin
         case (state)
            ST_FETCH: state <= ST_EXEC;
            ST_EXEC:  state <= ST_FETCH;
            ST_HALT:  state <= ST_HALT;
            default:  state <= ST_FETCH;
         endcase
      end
   end

`ifdef MIPS_MULT_EN
   localparam logic HILO_EN = 1'b1;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;

   assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
   assign prod_u = {32'h0, rs_i} * {32'h0, rt_i};

   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == ST_EXEC && !stall_i && op == OP_SPECIAL) begin
         case (fn)
            FN_MULT:  {hi, lo} <= prod_s;
            FN_MULTU: {hi, lo} <= prod_u;
            FN_MTHI:  hi <= rs_i;
            FN_MTLO:  lo <= rs_i;
            default: ;
         endcase
      end
   end
`else
   localparam logic HILO_EN = 1'b0;
   assign hi = '0;
   assign lo = '0;
`endif

   always_comb begin
      writes_gpr = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      dest       = DEST_RT;
      case (op)
         OP_SPECIAL: begin
            dest = DEST_RD;
            case (fn)
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JALR,
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
               FN_NOR, FN_SLT, FN_SLTU: writes_gpr = 1'b1;
               FN_MFHI, FN_MFLO:        writes_gpr = HILO_EN;
               default: ;
            endcase
         end
         // Link register is written whether or not the branch is taken.
         OP_REGIMM: begin
            dest       = DEST_R31;
            writes_gpr = (rt_f == RI_BLTZAL) || (rt_f == RI_BGEZAL);
         end
         OP_JAL: begin
            dest       = DEST_R31;
            writes_gpr = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
            writes_gpr = 1'b1;
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            writes_gpr = 1'b1;
            is_load    = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: is_store = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      pc_write_en_o      = 1'b0;
      ir_write_en_o      = 1'b0;
      ram_read_en_o      = 1'b0;
      ram_write_en_o     = 1'b0;
      ram_byte_en_o      = 4'h0;
      ram_addr_sel_o     = 1'b0;
      regfile_write_en_o = 1'b0;
      if (!reset) begin
         case (state)
            ST_FETCH: begin
               ram_read_en_o = 1'b1;
               ram_byte_en_o = 4'hF;
               ir_write_en_o = !stall_i;
            end
            ST_EXEC: begin
               pc_write_en_o      = !stall_i;
               regfile_write_en_o = writes_gpr && !stall_i;
               ram_read_en_o      = is_load;
               ram_write_en_o     = is_store;
               ram_addr_sel_o     = is_load || is_store;
               ram_byte_en_o      = mem_byte_en;
            end
            default: ;
         endcase
      end
   end

   assign state_o              = state;
   assign regfile_addr_3_sel_o = dest;

   mips_exec_alu u_alu (
      .instr_i             (instr_i),
      .rs_i                (rs_i),
      .rt_i                (rt_i),
      .pc_i                (pc_i),
      .ram_readdata_i      (ram_readdata_i),
      .hi_i                (hi),
      .lo_i                (lo),
      .wb_data_o           (wb_data_o),
      .store_data_o        (store_data_o),
      .effective_address_o (effective_address_o),
      .mem_byte_en_o       (mem_byte_en),
      .b_cond_met_o        (b_cond_met_o)
   );

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Bench for mips_exec_ctrl: directed vector table, hand sequences for
// stall/reset/halt/multiply, and randomized cycles against a reference model.
module tb_mips_exec_ctrl;

   logic        clk = 1'b0;
   logic        reset, halt_i, stall_i;
   logic [31:0] instr_i, rs_i, rt_i, pc_i, ram_readdata_i;
   logic [1:0]  state_o, regfile_addr_3_sel_o;
   logic        pc_write_en_o, ir_write_en_o, ram_read_en_o, ram_write_en_o;
   logic [3:0]  ram_byte_en_o;
   logic        ram_addr_sel_o, regfile_write_en_o, b_cond_met_o;
   logic [31:0] wb_data_o, store_data_o, effective_address_o;

   int checks = 0, failures = 0;

`ifdef MIPS_MULT_EN
   localparam bit MULT_EN = 1'b1;
`else
   localparam bit MULT_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   mips_exec_ctrl dut (
      .clk(clk), .reset(reset), .halt_i(halt_i), .stall_i(stall_i),
      .instr_i(instr_i), .rs_i(rs_i), .rt_i(rt_i), .pc_i(pc_i),
      .ram_readdata_i(ram_readdata_i), .state_o(state_o),
      .pc_write_en_o(pc_write_en_o), .ir_write_en_o(ir_write_en_o),
      .ram_read_en_o(ram_read_en_o), .ram_write_en_o(ram_write_en_o),
      .ram_byte_en_o(ram_byte_en_o), .ram_addr_sel_o(ram_addr_sel_o),
      .regfile_write_en_o(regfile_write_en_o),
      .regfile_addr_3_sel_o(regfile_addr_3_sel_o), .wb_data_o(wb_data_o),
      .store_data_o(store_data_o), .effective_address_o(effective_address_o),
      .b_cond_met_o(b_cond_met_o)
   );

   typedef struct {
      logic [31:0] wb, ea, sd;
      logic [3:0]  be;
      logic        bc, we;
      logic [1:0]  sel;
      logic        ld, st;
   } exp_t;

   typedef struct {
      logic [31:0] ins, rs, rt, pc, rd;
      exp_t        e;
   } vec_t;

   logic [31:0] m_hi = '0, m_lo = '0;
   int          m_state;

   logic [5:0] FN_LIST [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
   logic [5:0] OP_LIST [23] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20,
                                6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
   logic [4:0] RI_LIST [4]  = '{5'h00, 5'h01, 5'h10, 5'h11};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {state, pc_we, ir_we, rd_en, wr_en, byte_en, addr_sel, rf_we}
   function automatic logic [31:0] ctrl_now();
      return {20'h0, state_o, pc_write_en_o, ir_write_en_o, ram_read_en_o, ram_write_en_o,
              ram_byte_en_o, ram_addr_sel_o, regfile_write_en_o};
   endfunction

   function automatic logic [31:0] fetch_exp(input logic stall);
      return {20'h0, 2'd0, 1'b0, !stall, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
   endfunction

   function automatic vec_t mk(input logic [31:0] ins, rs, rt, pc, rd, wb, ea, sd,
                               input logic [3:0] be, input logic bc, we,
                               input logic [1:0] sel, input logic ld, st);
      vec_t v;
      v.ins = ins; v.rs = rs; v.rt = rt; v.pc = pc; v.rd = rd;
      v.e.wb = wb; v.e.ea = ea; v.e.sd = sd; v.e.be = be; v.e.bc = bc;
      v.e.we = we; v.e.sel = sel; v.e.ld = ld; v.e.st = st;
      return v;
   endfunction

   // Reference model: instruction semantics straight from the ISA rules.
   function automatic exp_t model(input logic [31:0] ins, rs, rt, pc, rd);
      exp_t        e;
      logic [5:0]  op = ins[31:26];
      logic [5:0]  fn = ins[5:0];
      logic [4:0]  rtf = ins[20:16];
      int          sa = int'(ins[10:6]);
      int          sv = int'(rs[4:0]);
      logic [31:0] simm = {{16{ins[15]}}, ins[15:0]};
      logic [31:0] zimm = {16'h0, ins[15:0]};
      logic [31:0] br = pc + 32'd4 + (simm << 2);
      logic [31:0] a = rs + simm;
      int          off = int'(a[1:0]);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'((rd >> (8 * (3 - off))) & 32'hFF);
      h = (off >= 2) ? rd[15:0] : rd[31:16];
      e = '{wb: 0, ea: 0, sd: 0, be: 0, bc: 0, we: 0, sel: 0, ld: 0, st: 0};
      case (op)
         6'h00: begin
            e.sel = 2'd0; e.we = 1'b1;
            case (fn)
               6'h00: e.wb = rt << sa;
               6'h02: e.wb = rt >> sa;
               6'h03: e.wb = $signed(rt) >>> sa;
               6'h04: e.wb = rt << sv;
               6'h06: e.wb = rt >> sv;
               6'h07: e.wb = $signed(rt) >>> sv;
               6'h08: begin e.we = 1'b0; e.ea = rs; e.bc = 1'b1; end
               6'h09: begin e.ea = rs; e.bc = 1'b1; e.wb = pc + 32'd8; end
               6'h10: begin e.wb = m_hi; e.we = MULT_EN; end
               6'h12: begin e.wb = m_lo; e.we = MULT_EN; end
               6'h20, 6'h21: e.wb = rs + rt;
               6'h22, 6'h23: e.wb = rs - rt;
               6'h24: e.wb = rs & rt;
               6'h25: e.wb = rs | rt;
               6'h26: e.wb = rs ^ rt;
               6'h27: e.wb = ~(rs | rt);
               6'h2a: e.wb = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
               6'h2b: e.wb = (rs < rt) ? 32'd1 : 32'd0;
               default: e.we = 1'b0;
            endcase
         end
         6'h01: begin
            if (rtf == 5'h00 || rtf == 5'h01 || rtf == 5'h10 || rtf == 5'h11) begin
               e.ea = br;
               e.bc = (rtf[0] == 1'b1) ? ($signed(rs) >= 0) : ($signed(rs) < 0);
               if (rtf[4]) begin e.we = 1'b1; e.sel = 2'd2; e.wb = pc + 32'd8; end
            end
         end
         6'h02, 6'h03: begin
            e.ea = {4'((pc + 32'd4) >> 28), ins[25:0], 2'b00};
            e.bc = 1'b1;
            if (op == 6'h03) begin e.we = 1'b1; e.sel = 2'd2; e.wb = pc + 32'd8; end
         end
         6'h04, 6'h05, 6'h06, 6'h07: begin
            e.ea = br;
            case (op)
               6'h04:   e.bc = (rs == rt);
               6'h05:   e.bc = (rs != rt);
               6'h06:   e.bc = ($signed(rs) <= 0);
               default: e.bc = ($signed(rs) > 0);
            endcase
         end
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
            e.we = 1'b1; e.sel = 2'd1;
            case (op)
               6'h0a:   e.wb = ($signed(rs) < $signed(simm)) ? 32'd1 : 32'd0;
               6'h0b:   e.wb = (rs < simm) ? 32'd1 : 32'd0;
               6'h0c:   e.wb = rs & zimm;
               6'h0d:   e.wb = rs | zimm;
               6'h0e:   e.wb = rs ^ zimm;
               6'h0f:   e.wb = zimm << 16;
               default: e.wb = rs + simm;
            endcase
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            e.we = 1'b1; e.sel = 2'd1; e.ld = 1'b1; e.be = 4'hF;
            e.ea = a & 32'hFFFF_FFFC;
            case (op)
               6'h20:   e.wb = 32'($signed(b));
               6'h24:   e.wb = 32'(b);
               6'h21:   e.wb = 32'($signed(h));
               6'h25:   e.wb = 32'(h);
               default: e.wb = rd;
            endcase
         end
         6'h28, 6'h29, 6'h2b: begin
            e.st = 1'b1;
            e.ea = a & 32'hFFFF_FFFC;
            case (op)
               6'h28:   begin e.be = 4'(1 << off); e.sd = {rt[7:0], rt[7:0], rt[7:0], rt[7:0]}; end
               6'h29:   begin e.be = (off >= 2) ? 4'b1100 : 4'b0011; e.sd = {rt[15:0], rt[15:0]}; end
               default: begin e.be = 4'hF; e.sd = rt; end
            endcase
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic chk_exec(input string nm, input exp_t e, input logic stall);
      chk({nm, "_ctrl"}, ctrl_now(),
          {20'h0, 2'd1, !stall, 1'b0, e.ld, e.st, e.be, e.ld | e.st, e.we & !stall});
      chk({nm, "_ea"}, effective_address_o, e.ea);
      chk({nm, "_bc"}, 32'(b_cond_met_o), 32'(e.bc));
      if (e.we) begin
         chk({nm, "_wb"}, wb_data_o, e.wb);
         chk({nm, "_sel"}, 32'(regfile_addr_3_sel_o), 32'(e.sel));
      end
      if (e.st) chk({nm, "_sd"}, store_data_o, e.sd);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 2) begin
         w[31:26] = 6'h00;
         w[5:0]   = FN_LIST[$urandom_range(0, 23)];
      end else if (k <= 8) begin
         w[31:26] = OP_LIST[$urandom_range(0, 22)];
         if (w[31:26] == 6'h01) w[20:16] = RI_LIST[$urandom_range(0, 3)];
      end
      return w;
   endfunction

   task automatic set_in(input logic [31:0] ins, rs, rt, pc, rd);
      instr_i = ins; rs_i = rs; rt_i = rt; pc_i = pc; ram_readdata_i = rd;
   endtask

   vec_t tv[$];

   initial begin
      exp_t e;
      longint          ps;
      longint unsigned pu;

      tv.push_back(mk(32'h2422FFFF, 32'd5, 0, 0, 0, 32'h4, 0, 0, 4'h0, 0, 1, 2'd1, 0, 0));
      tv.push_back(mk(32'h80220000, 32'h1003, 0, 0, 32'h11223380, 32'hFFFFFF80, 32'h1000, 0, 4'hF, 0, 1, 2'd1, 1, 0));
      tv.push_back(mk(32'h90220000, 32'h1003, 0, 0, 32'h11223380, 32'h00000080, 32'h1000, 0, 4'hF, 0, 1, 2'd1, 1, 0));
      tv.push_back(mk(32'hA4220000, 32'h2002, 32'hABCD1234, 0, 0, 0, 32'h2000, 32'h12341234, 4'b1100, 0, 0, 2'd1, 0, 1));
      tv.push_back(mk(32'h10220003, 32'h7, 32'h7, 32'h100, 0, 0, 32'h110, 0, 4'h0, 1, 0, 2'd1, 0, 0));
      tv.push_back(mk(32'h0C000040, 0, 0, 32'hBFC00000, 0, 32'hBFC00008, 32'hB0000100, 0, 4'h0, 1, 1, 2'd2, 0, 0));
      tv.push_back(mk(32'h14220003, 32'h7, 32'h7, 32'h100, 0, 0, 32'h110, 0, 4'h0, 0, 0, 2'd1, 0, 0));
      tv.push_back(mk(32'h00021903, 0, 32'h80000000, 0, 0, 32'hF8000000, 0, 0, 4'h0, 0, 1, 2'd0, 0, 0));
      tv.push_back(mk(32'h2C22FFFF, 32'd5, 0, 0, 0, 32'h1, 0, 0, 4'h0, 0, 1, 2'd1, 0, 0));
      tv.push_back(mk(32'h30228001, 32'hFFFFFFFF, 0, 0, 0, 32'h00008001, 0, 0, 4'h0, 0, 1, 2'd1, 0, 0));
      tv.push_back(mk(32'h3C021234, 0, 0, 0, 0, 32'h12340000, 0, 0, 4'h0, 0, 1, 2'd1, 0, 0));
      tv.push_back(mk(32'h04300010, 32'd5, 0, 32'h200, 0, 32'h208, 32'h244, 0, 4'h0, 0, 1, 2'd2, 0, 0));
      tv.push_back(mk(32'h84220000, 32'h1002, 0, 0, 32'h11223380, 32'h00003380, 32'h1000, 0, 4'hF, 0, 1, 2'd1, 1, 0));
      tv.push_back(mk(32'h94220000, 32'h1000, 0, 0, 32'h80001111, 32'h00008000, 32'h1000, 0, 4'hF, 0, 1, 2'd1, 1, 0));
      tv.push_back(mk(32'hA0220000, 32'h2001, 32'h000000AB, 0, 0, 0, 32'h2000, 32'hABABABAB, 4'b0010, 0, 0, 2'd1, 0, 1));
      tv.push_back(mk(32'h00200008, 32'h00400000, 0, 0, 0, 0, 32'h00400000, 0, 4'h0, 1, 0, 2'd0, 0, 0));
      tv.push_back(mk(32'hFC000000, 32'h5, 32'h6, 32'h100, 0, 0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0));
      tv.push_back(mk(32'h00221822, 32'h80000000, 32'h1, 0, 0, 32'h7FFFFFFF, 0, 0, 4'h0, 0, 1, 2'd0, 0, 0));

      reset = 1'b1; halt_i = 1'b0; stall_i = 1'b0;
      set_in(0, 0, 0, 0, 0);
      tick();
      chk("reset_ctrl", ctrl_now(), 32'h0);
      reset = 1'b0; #1;
      chk("fetch_ctrl", ctrl_now(), fetch_exp(1'b0));
      stall_i = 1'b1;
      tick();
      chk("fetch_stall", ctrl_now(), fetch_exp(1'b1));
      stall_i = 1'b0;
      tick();

      foreach (tv[i]) begin
         set_in(tv[i].ins, tv[i].rs, tv[i].rt, tv[i].pc, tv[i].rd);
         #1;
         chk_exec($sformatf("vec%0d", i), tv[i].e, 1'b0);
         tick();
         tick();
      end

      // Signed multiply then read back HI and LO.
      set_in(32'h00220018, 32'hFFFFFFFE, 32'h3, 0, 0);
      #1; tick(); tick();
      set_in(32'h00001810, 0, 0, 0, 0);
      #1;
      chk("mfhi_we", 32'(regfile_write_en_o), 32'(MULT_EN));
      chk("mfhi_wb", wb_data_o, MULT_EN ? 32'hFFFFFFFF : 32'h0);
      tick(); tick();
      set_in(32'h00001812, 0, 0, 0, 0);
      #1;
      chk("mflo_wb", wb_data_o, MULT_EN ? 32'hFFFFFFFA : 32'h0);

      // Reset while in EXEC: strobes drop immediately, MTHI never lands.
      set_in(32'h00200011, 32'h12345678, 0, 0, 0);
      reset = 1'b1; #1;
      chk("rst_exec_ctrl", ctrl_now(), {20'h0, 2'd1, 10'h0});
      tick();
      reset = 1'b0; #1;
      chk("rst_exec_fetch", ctrl_now(), fetch_exp(1'b0));
      tick();
      set_in(32'h00001810, 0, 0, 0, 0);
      #1;
      chk("rst_hi_cleared", wb_data_o, 32'h0);

      m_hi = '0; m_lo = '0; m_state = 1;
      for (int n = 0; n < 400; n++) begin
         stall_i = ($urandom_range(0, 3) == 0);
         set_in(gen_instr(), $urandom, $urandom, $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) rt_i = rs_i;
         if ($urandom_range(0, 3) == 0) rs_i = 32'($urandom_range(0, 2)) - 32'd1;
         #1;
         e = model(instr_i, rs_i, rt_i, pc_i, ram_readdata_i);
         if (m_state == 0) chk("rnd_fetch", ctrl_now(), fetch_exp(stall_i));
         else              chk_exec($sformatf("rnd%0d", n), e, stall_i);
         if (MULT_EN && m_state == 1 && !stall_i && instr_i[31:26] == 6'h00) begin
            case (instr_i[5:0])
               6'h18: begin ps = longint'($signed(rs_i)) * longint'($signed(rt_i)); {m_hi, m_lo} = ps; end
               6'h19: begin pu = {32'h0, rs_i} * {32'h0, rt_i}; {m_hi, m_lo} = pu; end
               6'h11: m_hi = rs_i;
               6'h13: m_lo = rs_i;
               default: ;
            endcase
         end
         if (!stall_i) m_state = 1 - m_state;
         tick();
      end

      // Halt wins over stall and sticks until reset.
      stall_i = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      stall_i = 1'b1; halt_i = 1'b1;
      tick();
      halt_i = 1'b0; stall_i = 1'b0; #1;
      chk("halt_enter", ctrl_now(), {20'h0, 2'd2, 10'h0});
      tick(); tick(); tick();
      chk("halt_sticky", ctrl_now(), {20'h0, 2'd2, 10'h0});
      reset = 1'b1; tick(); reset = 1'b0; #1;
      chk("halt_reset", ctrl_now(), fetch_exp(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
